// File: rtl/layer_input_feeder.sv
// Assembles N_IN streamed activations into a shadow bank and presents it atomically on a_bus.
// Latency: last word accepted at edge E, transfer at E+1 at earliest; node_sample SETTLE cycles after frame_valid.
// Backpressure: in_ready drops only while a complete frame waits for the node pipeline to settle.
module layer_input_feeder #(
    parameter int N_IN   = 30,
    parameter int DW     = 8,
    parameter int SETTLE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [N_IN*DW-1:0]   a_bus,
    output logic                 frame_valid,
    output logic                 node_sample,
    output logic                 err_len,
    input  logic                 err_clr
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [SW-1:0]   settle_cnt;
    logic [DW-1:0]   shadow [N_IN];

    logic accept;
    logic fill_accept;
    logic at_last_idx;
    logic len_violation;
    logic xfer;

    assign in_ready      = (state != FULL);
    assign accept        = in_valid && in_ready;
    assign fill_accept   = accept && (state == FILL);
    assign at_last_idx   = (idx == IDX_LAST);
    assign len_violation = fill_accept && (at_last_idx != in_last);
    assign xfer          = (state == FULL) && (settle_cnt == '0);

    // Shadow bank carries no reset; its contents only matter once a full frame has been written.
    always_ff @(posedge clk) begin
        if (fill_accept) begin
            shadow[idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (at_last_idx) begin
                            idx   <= '0;
                            state <= in_last ? FULL : DISCARD;
                        end else if (in_last) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && in_last) begin
                        state <= FILL;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        state <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                    idx   <= '0;
                end
            endcase
        end
    end

    // A new violation on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_len <= 1'b0;
        end else if (len_violation) begin
            err_len <= 1'b1;
        end else if (err_clr) begin
            err_len <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_bus       <= '0;
            frame_valid <= 1'b0;
            node_sample <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            frame_valid <= xfer;
            node_sample <= (settle_cnt == SW'(1));
            if (xfer) begin
                settle_cnt <= SETTLE_V;
                for (int k = 0; k < N_IN; k++) begin
                    a_bus[k*DW +: DW] <= shadow[k];
                end
            end else if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_input_feeder.sv
// Bench for layer_input_feeder: two instances (SETTLE=3 and SETTLE=40) against a frame-level timestamp model.
module tb_layer_input_feeder;

    localparam int N  = 30;
    localparam int DW = 8;
    localparam int W  = N * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] dd  [2];
    logic          dv  [2];
    logic          dl  [2];
    logic          dc  [2];
    logic          rdy [2];
    logic [W-1:0]  ab  [2];
    logic          fv  [2];
    logic          ns  [2];
    logic          er  [2];

    always #5 clk = ~clk;

    layer_input_feeder #(.N_IN(N), .DW(DW), .SETTLE(3)) dut0 (
        .clk(clk), .reset(rst), .in_data(dd[0]), .in_valid(dv[0]), .in_last(dl[0]),
        .in_ready(rdy[0]), .a_bus(ab[0]), .frame_valid(fv[0]), .node_sample(ns[0]),
        .err_len(er[0]), .err_clr(dc[0])
    );

    layer_input_feeder #(.N_IN(N), .DW(DW), .SETTLE(40)) dut1 (
        .clk(clk), .reset(rst), .in_data(dd[1]), .in_valid(dv[1]), .in_last(dl[1]),
        .in_ready(rdy[1]), .a_bus(ab[1]), .frame_valid(fv[1]), .node_sample(ns[1]),
        .err_len(er[1]), .err_clr(dc[1])
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int settle_v [2] = '{3, 40};

    // Reference model: partial frame buffer, pending complete frame, and the edge of the last transfer.
    bit           m_full [2];
    bit           m_disc [2];
    bit           m_err  [2];
    bit           m_fv   [2];
    bit           m_ns   [2];
    int           m_n    [2];
    int           m_lx   [2];
    int           m_fv_tot [2];
    logic [W-1:0] m_cur  [2];
    logic [W-1:0] m_pend [2];
    logic [W-1:0] m_abus [2];

    int fv_seen [2];
    int ns_seen [2];
    int fv_at   [2];
    int ns_at   [2];
    int low_cnt [2];

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    int  gap      [2];
    bit  clr_once [2];
    bit  rnd_clr = 1'b0;

    function automatic int q_size(int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [9:0] q_front(int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(int u);
        logic [9:0] e;
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic q_push(int u, logic [9:0] e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check(string tag, int u, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, u, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_full[u] = 0; m_disc[u] = 0; m_err[u] = 0; m_fv[u] = 0; m_ns[u] = 0;
            m_n[u] = 0; m_lx[u] = -1000; m_abus[u] = '0; m_cur[u] = '0; m_pend[u] = '0;
        end
    endtask

    task automatic model_edge(int u, logic v, logic [DW-1:0] d, logic l, logic c);
        bit old_full;
        bit set_e;
        old_full = m_full[u];
        set_e    = 0;
        m_ns[u]  = (m_lx[u] + settle_v[u] == edge_n);
        m_fv[u]  = 0;
        if (old_full && edge_n >= m_lx[u] + settle_v[u] + 1) begin
            m_abus[u] = m_pend[u];
            m_fv[u]   = 1;
            m_fv_tot[u]++;
            m_lx[u]   = edge_n;
            m_full[u] = 0;
        end
        if (v && !old_full) begin
            if (m_disc[u]) begin
                if (l) m_disc[u] = 0;
            end else begin
                m_cur[u][m_n[u]*DW +: DW] = d;
                m_n[u]++;
                if (m_n[u] == N) begin
                    if (l) begin
                        m_pend[u] = m_cur[u];
                        m_full[u] = 1;
                    end else begin
                        set_e     = 1;
                        m_disc[u] = 1;
                    end
                    m_n[u] = 0;
                end else if (l) begin
                    set_e  = 1;
                    m_n[u] = 0;
                end
            end
        end
        if (set_e)  m_err[u] = 1;
        else if (c) m_err[u] = 0;
    endtask

    task automatic verify();
        for (int u = 0; u < 2; u++) begin
            check("in_ready",    u, W'(rdy[u]), W'(!m_full[u]));
            check("frame_valid", u, W'(fv[u]),  W'(m_fv[u]));
            check("node_sample", u, W'(ns[u]),  W'(m_ns[u]));
            check("err_len",     u, W'(er[u]),  W'(m_err[u]));
            check("a_bus",       u, ab[u],      m_abus[u]);
            if (!rdy[u]) low_cnt[u]++;
            if (fv[u]) begin fv_seen[u]++; fv_at[u] = edge_n; end
            if (ns[u]) begin ns_seen[u]++; ns_at[u] = edge_n; end
        end
    endtask

    task automatic drive();
        for (int u = 0; u < 2; u++) begin
            logic [9:0] e;
            if (q_size(u) > 0 && int'($urandom_range(99)) >= gap[u]) begin
                e = q_front(u);
                dv[u] = 1'b1; dd[u] = e[7:0]; dl[u] = e[8]; dc[u] = e[9];
            end else begin
                dv[u] = 1'b0; dd[u] = 8'($urandom); dl[u] = 1'($urandom); dc[u] = 1'b0;
            end
            if (clr_once[u]) begin dc[u] = 1'b1; clr_once[u] = 0; end
            if (rnd_clr && $urandom_range(19) == 0) dc[u] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        for (int u = 0; u < 2; u++) begin
            if (dv[u] && !m_full[u]) q_pop(u);
            model_edge(u, dv[u], dd[u], dl[u], dc[u]);
        end
        @(negedge clk);
        verify();
        drive();
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic run_frames(int budget);
        int c = 0;
        while ((q_size(0) > 0 || q_size(1) > 0) && c < budget) begin
            step();
            c++;
        end
        check("drain_timeout", 0, W'(q_size(0) + q_size(1)), '0);
    endtask

    task automatic push_frame(int u, int len, int base, int lastpos, int clrpos);
        for (int i = 1; i <= len; i++) begin
            q_push(u, {(i == clrpos), (i == lastpos), 8'(base + i - 1)});
        end
    endtask

    task automatic push_rand(int u);
        int len;
        len = ($urandom_range(9) < 7) ? N : int'($urandom_range(1, 40));
        for (int i = 1; i <= len; i++) begin
            q_push(u, {1'b0, (i == len), 8'($urandom)});
        end
    endtask

    task automatic check_reset_outputs(string tag);
        for (int u = 0; u < 2; u++) begin
            check({tag, "_ready"}, u, W'(rdy[u]), W'(1));
            check({tag, "_fv"},    u, W'(fv[u]),  '0);
            check({tag, "_ns"},    u, W'(ns[u]),  '0);
            check({tag, "_err"},   u, W'(er[u]),  '0);
            check({tag, "_abus"},  u, ab[u],      '0);
        end
    endtask

    // Reset is raised between edges so its effect is observed before any clock edge.
    task automatic do_reset(string tag);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin
            dv[u] = 1'b0; dl[u] = 1'b0; dc[u] = 1'b0; dd[u] = '0;
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int fv0;
        int ns0;
        for (int u = 0; u < 2; u++) begin
            dv[u] = 1'b0; dl[u] = 1'b0; dc[u] = 1'b0; dd[u] = '0;
            gap[u] = 0; clr_once[u] = 0; fv_seen[u] = 0; ns_seen[u] = 0;
            fv_at[u] = 0; ns_at[u] = 0; low_cnt[u] = 0; m_fv_tot[u] = 0;
        end
        model_reset();
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        drive();
        idle(3);

        // Single frame 1..30
        push_frame(0, N, 1, N, 0);
        run_frames(200);
        idle(8);
        check("single_lane0",  0, W'(ab[0][7:0]),          W'(1));
        check("single_lane29", 0, W'(ab[0][29*DW +: DW]),  W'(30));
        check("single_fv_cnt", 0, W'(fv_seen[0]),          W'(1));
        check("single_ns_cnt", 0, W'(ns_seen[0]),          W'(1));
        check("single_ns_gap", 0, W'(ns_at[0] - fv_at[0]), W'(3));
        check("single_err",    0, W'(er[0]),               '0);

        // Back-to-back frames with in_valid held high
        low_cnt[0] = 0;
        fv0 = fv_seen[0];
        ns0 = ns_seen[0];
        push_frame(0, N, 8'h01, N, 0);
        push_frame(0, N, 8'h80, N, 0);
        run_frames(300);
        idle(8);
        check("b2b_ready_low", 0, W'(low_cnt[0]),          W'(2));
        check("b2b_fv_cnt",    0, W'(fv_seen[0] - fv0),    W'(2));
        check("b2b_ns_cnt",    0, W'(ns_seen[0] - ns0),    W'(2));
        check("b2b_lane0",     0, W'(ab[0][7:0]),          W'(8'h80));
        check("b2b_lane29",    0, W'(ab[0][29*DW +: DW]),  W'(8'h9D));

        // Long settle: second frame waits in FULL
        low_cnt[1] = 0;
        push_frame(1, N, 8'h10, N, 0);
        push_frame(1, N, 8'hC0, N, 0);
        run_frames(400);
        idle(60);
        check("settle40_ready_low", 1, W'(low_cnt[1]),     W'(12));
        check("settle40_fv_cnt",    1, W'(fv_seen[1]),     W'(2));
        check("settle40_lane0",     1, W'(ab[1][7:0]),     W'(8'hC0));

        // Short frame then a good frame
        fv0 = fv_seen[0];
        push_frame(0, 10, 8'h55, 10, 0);
        push_frame(0, N, 8'h40, N, 0);
        run_frames(300);
        idle(8);
        check("short_err",    0, W'(er[0]),             W'(1));
        check("short_fv_cnt", 0, W'(fv_seen[0] - fv0),  W'(1));
        check("short_lane0",  0, W'(ab[0][7:0]),        W'(8'h40));

        clr_once[0] = 1;
        idle(2);
        check("clr_err", 0, W'(er[0]), '0);

        // Long frame with err_clr coinciding with the violation, then a good frame
        fv0 = fv_seen[0];
        push_frame(0, 35, 8'hA0, 35, N);
        push_frame(0, N, 8'h20, N, 0);
        run_frames(300);
        idle(8);
        check("long_err",    0, W'(er[0]),            W'(1));
        check("long_fv_cnt", 0, W'(fv_seen[0] - fv0), W'(1));
        check("long_lane0",  0, W'(ab[0][7:0]),       W'(8'h20));
        check("long_lane29", 0, W'(ab[0][29*DW +: DW]), W'(8'h3D));

        // Reset after word 15
        push_frame(0, N, 8'h70, N, 0);
        c = 0;
        while (m_n[0] != 15 && c < 200) begin step(); c++; end
        check("reach_word15", 0, W'(m_n[0]), W'(15));
        do_reset("rst_mid");
        fv0 = fv_seen[0];
        ns0 = ns_seen[0];
        push_frame(0, N, 8'h01, N, 0);
        run_frames(200);
        idle(8);
        check("post_rst_fv_cnt", 0, W'(fv_seen[0] - fv0),   W'(1));
        check("post_rst_ns_cnt", 0, W'(ns_seen[0] - ns0),   W'(1));
        check("post_rst_ns_gap", 0, W'(ns_at[0] - fv_at[0]), W'(3));

        // Reset during settle
        push_frame(0, N, 8'h33, N, 0);
        c = 0;
        while (!m_fv[0] && c < 200) begin step(); c++; end
        check("reach_xfer", 0, W'(fv[0]), W'(1));
        step();
        ns0 = ns_seen[0];
        fv0 = fv_seen[0];
        do_reset("rst_settle");
        idle(10);
        check("no_ns_after_rst", 0, W'(ns_seen[0]), W'(ns0));
        check("no_fv_after_rst", 0, W'(fv_seen[0]), W'(fv0));
        push_frame(0, N, 8'h90, N, 0);
        run_frames(200);
        idle(8);
        check("fresh_fv_cnt", 0, W'(fv_seen[0] - fv0),    W'(1));
        check("fresh_ns_gap", 0, W'(ns_at[0] - fv_at[0]), W'(3));

        // Randomized frames, gaps and err_clr on both instances
        rnd_clr = 1'b1;
        gap[0] = int'($urandom_range(0, 50));
        gap[1] = int'($urandom_range(0, 50));
        for (int f = 0; f < 40; f++) begin
            push_rand(0);
            push_rand(1);
        end
        run_frames(20000);
        rnd_clr = 1'b0;
        idle(60);
        check("total_fv0", 0, W'(fv_seen[0]), W'(m_fv_tot[0]));
        check("total_fv1", 1, W'(fv_seen[1]), W'(m_fv_tot[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_input_feeder.md
# layer_input_feeder

Streaming front end for one fully connected layer of node instances. It accepts 8-bit signed activations one per cycle over a valid/ready stream and assembles N_IN of them into a shadow bank. It then transfers the bank atomically onto the layer's parallel activation bus, holding it stable for the node pipeline depth. A strobe marks the cycle in which the node outputs for that frame are valid.

## Interface
- N_IN, 30: activations per frame; these drive lanes A0x..A(N_IN-1)x of every node in the layer.
- DW, 8: activation width, two's complement.
- SETTLE, 3: node pipeline depth in cycles (input register, accumulate, ReLU/saturate register).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DW  activation word.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final word of a frame; qualified by in_valid.
- in_ready  out  1  feeder accepts the word this cycle.
- a_bus  out  N_IN*DW  lane k is a_bus[k*DW +: DW]; lane 0 holds the first word of the frame.
- frame_valid  out  1  one-cycle pulse in the first cycle a new a_bus is presented.
- node_sample  out  1  one-cycle pulse when the node outputs for the current a_bus are valid.
- err_len  out  1  sticky flag for a frame-length violation.
- err_clr  in  1  clears err_len.

## Operation
- A word is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state != FULL). It is registered-state based only, with no combinational path from in_valid.
- Index counter idx counts 0..N_IN-1. An accepted word in FILL is written to shadow[idx].
- The FSM has three states: FILL, FULL, DISCARD.
  - FILL, accepted word, idx < N_IN-1, in_last=0: idx++.
  - FILL, accepted word, idx < N_IN-1, in_last=1: set err_len, idx<=0, stay in FILL. The partial frame is dropped.
  - FILL, accepted word, idx == N_IN-1, in_last=1: go to FULL, idx<=0.
  - FILL, accepted word, idx == N_IN-1, in_last=0: set err_len, idx<=0, go to DISCARD.
  - DISCARD: accept and drop words. An accepted word with in_last=1 returns the FSM to FILL.
  - FULL: when settle_cnt == 0, transfer on that edge:
    - a_bus <= shadow
    - frame_valid <= 1 for one cycle
    - settle_cnt <= SETTLE
    - go to FILL
- settle_cnt decrements by 1 on each edge while it is nonzero. On the edge where it goes from 1 to 0, node_sample <= 1 for one cycle.
- a_bus changes only on a transfer. Between transfers it holds its value indefinitely.
- err_len is set by the violation conditions above and cleared by err_clr. If both happen on the same edge, set wins.
- No arithmetic is performed. Data passes bit-exact; sign is not interpreted.

## Timing
- Reset values:
  - a_bus = 0, frame_valid = 0, node_sample = 0, err_len = 0
  - state = FILL, idx = 0, settle_cnt = 0, in_ready = 1
  - Shadow contents are don't-care.
- Reset asserted mid-frame or mid-settle aborts everything immediately. No frame_valid or node_sample pulse follows the deassertion.
- Latency:
  - Last word accepted at edge E → transfer at edge E+1 at earliest, which requires settle_cnt == 0.
  - frame_valid is high in the cycle after edge E+1.
  - node_sample is high in the cycle after edge E+1+SETTLE.
- Transfer at edge T. The next transfer can occur no earlier than edge T+SETTLE+1, so the minimum frame period is max(N_IN+1, SETTLE+1) cycles.
- The FILL of frame n+1 overlaps the settle of frame n. in_ready is low only while in FULL.
- Because in_ready is low in FULL, the last word of a frame and the first word of the next cannot be accepted on consecutive edges. There is one bubble per frame.

## Test plan
- Single frame: words 1..30 with in_last on word 30 → a_bus lane k = k+1; frame_valid pulses one cycle after the last accept; node_sample pulses exactly 3 cycles after frame_valid; err_len = 0.
- Back-to-back frames with in_valid held high, frames 0x01.. then 0x80.. → in_ready low for exactly one cycle per frame; a_bus switches atomically to 0x80..; no lane mixing; two frame_valid and two node_sample pulses.
- With SETTLE=40 (overridden), a second frame completes early → FSM sits in FULL with in_ready low until settle_cnt = 0; a_bus keeps frame 1 until node_sample for frame 1 has pulsed.
- Short frame: in_last on word 10 → err_len = 1, no frame_valid, a_bus unchanged; the following 30-word frame is delivered correctly.
- Long frame: 35 words with in_last on word 35 → err_len = 1, words 31..35 dropped in DISCARD, no frame_valid; the next good frame is delivered; err_clr pulsed on the same edge as a new violation leaves err_len = 1.
- Reset asserted after word 15 of a frame, and separately during settle → all outputs return to reset values asynchronously; a fresh 30-word frame then produces normal timing.
